// File: rtl/wf_cic_ctrl.sv
// Sequencer for the waterfall CIC decimator: applies zoom, resets and flushes the CIC, then captures samples.
// Latency: config to cic_reset 1 cycle; cic_in_strobe lags adc_strobe 1 cycle; wr_strobe lags cic_out_strobe 1 cycle.
// Backpressure: cfg_ready low while RESET/FLUSH/CAPTURE; cap_start dropped outside FLUSH/ARMED.
module wf_cic_ctrl #(
  parameter int MD       = 18,
  parameter int ZOOM_MAX = 13,
  parameter int RST_CYC  = 2,
  parameter int FLUSH    = 6,
  parameter int CNT_W    = 11
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  input  logic [3:0]       i_cfg_zoom,
  output logic             o_cfg_ready,
  input  logic             i_cap_start,
  input  logic [CNT_W-1:0] i_cap_len,
  input  logic             i_adc_strobe,
  output logic             o_cic_reset,
  output logic [MD-1:0]    o_cic_decimation,
  output logic             o_cic_in_strobe,
  input  logic             i_cic_out_strobe,
  output logic             o_wr_strobe,
  output logic [CNT_W-1:0] o_wr_addr,
  output logic             o_cap_done,
  output logic             o_busy,
  output logic [3:0]       o_cur_zoom
);

  localparam int FW = $clog2(FLUSH + 1);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_FLUSH,
    S_ARMED,
    S_CAPTURE
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_rst_cnt;
  logic [FW-1:0]    r_flush_cnt;
  logic             r_pend;
  logic [CNT_W-1:0] r_pend_len;
  logic [CNT_W-1:0] r_cap_len;
  logic             r_cic_reset;
  logic [MD-1:0]    r_cic_decimation;
  logic             r_in_strobe;
  logic             r_wr_strobe;
  logic [CNT_W-1:0] r_wr_addr;
  logic             r_cap_done;
  logic             r_busy;
  logic [3:0]       r_cur_zoom;

  logic [3:0]       w_zoom;
  logic [MD-1:0]    w_dec;
  logic             w_accept;
  logic             w_last_wr;

  // Clamp the requested zoom and turn it into a power-of-two decimation.
  assign w_zoom   = (i_cfg_zoom > 4'(ZOOM_MAX)) ? 4'(ZOOM_MAX) : i_cfg_zoom;
  assign w_dec    = {{(MD-1){1'b0}}, 1'b1} << w_zoom;

  // Commands are only taken while the CIC is idle or armed, never during reset.
  assign o_cfg_ready = !i_reset && ((r_state == S_IDLE) || (r_state == S_ARMED));
  assign w_accept    = o_cfg_ready && i_cfg_valid;

  // The write registered last cycle was the final one of this capture.
  assign w_last_wr = r_wr_strobe && (r_wr_addr == r_cap_len - 1'b1);

  // Sequencer: state, counters and every registered output in one place.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_rst_cnt        <= '0;
      r_flush_cnt      <= '0;
      r_pend           <= 1'b0;
      r_pend_len       <= '0;
      r_cap_len        <= '0;
      r_cic_reset      <= 1'b0;
      r_cic_decimation <= {{(MD-1){1'b0}}, 1'b1};
      r_in_strobe      <= 1'b0;
      r_wr_strobe      <= 1'b0;
      r_wr_addr        <= '0;
      r_cap_done       <= 1'b0;
      r_busy           <= 1'b0;
      r_cur_zoom       <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_cap_done  <= 1'b0;
      if (w_accept) begin
        // A config beats a simultaneous cap_start in ARMED.
        r_cur_zoom       <= w_zoom;
        r_cic_decimation <= w_dec;
        r_cic_reset      <= 1'b1;
        r_busy           <= 1'b1;
        r_in_strobe      <= 1'b0;
        r_rst_cnt        <= RW'(RST_CYC - 1);
        r_pend           <= 1'b0;
        r_state          <= S_RESET;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_in_strobe <= 1'b0;
          end
          S_RESET: begin
            if (r_rst_cnt == '0) begin
              r_cic_reset <= 1'b0;
              r_flush_cnt <= '0;
              r_in_strobe <= i_adc_strobe;
              r_state     <= S_FLUSH;
            end else begin
              r_in_strobe <= 1'b0;
              r_rst_cnt   <= r_rst_cnt - 1'b1;
            end
          end
          S_FLUSH: begin
            r_in_strobe <= i_adc_strobe;
            if (i_cap_start) begin
              r_pend     <= 1'b1;
              r_pend_len <= i_cap_len;
            end
            if (i_cic_out_strobe) begin
              if (r_flush_cnt == FW'(FLUSH - 1)) begin
                r_pend <= 1'b0;
                if (r_pend || i_cap_start) begin
                  r_cap_len <= i_cap_start ? i_cap_len : r_pend_len;
                  r_wr_addr <= '0;
                  r_state   <= S_CAPTURE;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_ARMED;
                end
              end else begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
              end
            end
          end
          S_ARMED: begin
            r_in_strobe <= i_adc_strobe;
            if (i_cap_start) begin
              r_cap_len <= i_cap_len;
              r_wr_addr <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            r_in_strobe <= i_adc_strobe;
            if ((r_cap_len == '0) || w_last_wr) begin
              r_cap_done <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_ARMED;
            end else if (i_cic_out_strobe) begin
              r_wr_strobe <= 1'b1;
            end
            if (r_wr_strobe) begin
              r_wr_addr <= r_wr_addr + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_cic_reset      = r_cic_reset;
  assign o_cic_decimation = r_cic_decimation;
  assign o_cic_in_strobe  = r_in_strobe;
  assign o_wr_strobe      = r_wr_strobe;
  assign o_wr_addr        = r_wr_addr;
  assign o_cap_done       = r_cap_done;
  assign o_busy           = r_busy;
  assign o_cur_zoom       = r_cur_zoom;

endmodule

// File: tb/tb_wf_cic_ctrl.sv
// Bench for wf_cic_ctrl: directed steps with random strobes, checked against a behavioural model.
// Latency: model predicts every output one clock after the inputs it sees.
// Backpressure: cfg_valid/cap_start offered freely; model decides acceptance.
module tb_wf_cic_ctrl;
  localparam int MD       = 18;
  localparam int ZOOM_MAX = 13;
  localparam int RST_CYC  = 2;
  localparam int FLUSH    = 6;
  localparam int CNT_W    = 11;

  logic             clk = 1'b0;
  logic             i_reset, i_cfg_valid, i_cap_start, i_adc_strobe, i_cic_out_strobe;
  logic [3:0]       i_cfg_zoom;
  logic [CNT_W-1:0] i_cap_len;
  logic             o_cfg_ready, o_cic_reset, o_cic_in_strobe, o_wr_strobe, o_cap_done, o_busy;
  logic [MD-1:0]    o_cic_decimation;
  logic [CNT_W-1:0] o_wr_addr;
  logic [3:0]       o_cur_zoom;

  always #5 clk = ~clk;

  wf_cic_ctrl #(.MD(MD), .ZOOM_MAX(ZOOM_MAX), .RST_CYC(RST_CYC), .FLUSH(FLUSH), .CNT_W(CNT_W)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_cfg_valid(i_cfg_valid), .i_cfg_zoom(i_cfg_zoom), .o_cfg_ready(o_cfg_ready),
    .i_cap_start(i_cap_start), .i_cap_len(i_cap_len), .i_adc_strobe(i_adc_strobe),
    .o_cic_reset(o_cic_reset), .o_cic_decimation(o_cic_decimation), .o_cic_in_strobe(o_cic_in_strobe),
    .i_cic_out_strobe(i_cic_out_strobe), .o_wr_strobe(o_wr_strobe), .o_wr_addr(o_wr_addr),
    .o_cap_done(o_cap_done), .o_busy(o_busy), .o_cur_zoom(o_cur_zoom)
  );

  int total = 0;
  int bad   = 0;
  int nwr   = 0;

  // Behavioural model: phases tracked as "cycles / strobes / samples still to go".
  bit m_cfgd, m_cap, m_pend;
  int m_rst_left, m_flush_left, m_cap_left, m_addr, m_plen;
  int e_dec = 1, e_zoom = 0, e_addr = 0;
  bit e_rst, e_ins, e_wr, e_done;

  function automatic bit m_busy();
    return (m_rst_left > 0) || (m_flush_left > 0) || m_cap;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit cv, input int z, input bit cs,
                            input int cl, input bit adc, input bit os);
    e_wr   = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_cfgd = 0; m_cap = 0; m_pend = 0;
      m_rst_left = 0; m_flush_left = 0; m_cap_left = 0; m_addr = 0;
      e_dec = 1; e_zoom = 0;
    end else if (!m_busy() && cv) begin
      e_zoom     = (z > ZOOM_MAX) ? ZOOM_MAX : z;
      e_dec      = 1 << e_zoom;
      m_rst_left = RST_CYC;
      m_cfgd     = 1;
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) m_flush_left = FLUSH;
    end else if (m_flush_left > 0) begin
      if (cs) begin m_pend = 1; m_plen = cl; end
      if (os) begin
        m_flush_left--;
        if (m_flush_left == 0 && m_pend) begin
          m_pend = 0; m_cap = 1; m_cap_left = m_plen; m_addr = 0;
        end
      end
    end else if (m_cap) begin
      if (m_cap_left == 0) begin
        e_done = 1; m_cap = 0;
      end else if (os) begin
        e_wr = 1; e_addr = m_addr; m_addr++; m_cap_left--;
      end
    end else if (m_cfgd && cs) begin
      m_cap = 1; m_cap_left = cl; m_addr = 0;
    end
    e_rst = (m_rst_left > 0);
    e_ins = adc && m_cfgd && (m_rst_left == 0);
  endtask

  // One clock: drive inputs, advance model, check outputs on the falling edge.
  task automatic cyc(input bit rst, input bit cv, input int z, input bit cs, input int cl);
    bit adc, os;
    adc = 1'($urandom % 2);
    os  = (($urandom % 3) == 0);
    i_reset = rst; i_cfg_valid = cv; i_cfg_zoom = 4'(z);
    i_cap_start = cs; i_cap_len = CNT_W'(cl);
    i_adc_strobe = adc; i_cic_out_strobe = os;
    model_step(rst, cv, z, cs, cl, adc, os);
    @(posedge clk);
    @(negedge clk);
    chk("cic_reset", 32'(o_cic_reset), 32'(e_rst));
    chk("cic_decimation", 32'(o_cic_decimation), 32'(e_dec));
    chk("cur_zoom", 32'(o_cur_zoom), 32'(e_zoom));
    chk("cic_in_strobe", 32'(o_cic_in_strobe), 32'(e_ins));
    chk("wr_strobe", 32'(o_wr_strobe), 32'(e_wr));
    chk("cap_done", 32'(o_cap_done), 32'(e_done));
    chk("busy", 32'(o_busy), 32'(m_busy()));
    chk("cfg_ready", 32'(o_cfg_ready), 32'(!rst && !m_busy()));
    if (e_wr) chk("wr_addr", 32'(o_wr_addr), 32'(e_addr));
    if (o_wr_strobe === 1'b1) nwr++;
  endtask

  task automatic settle(input string tag);
    for (int k = 0; k < 600; k++) begin
      if (o_busy !== 1'b1) break;
      cyc(0, 0, 0, 0, 0);
    end
    chk(tag, 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_cfg_valid = 1'b0; i_cfg_zoom = '0; i_cap_start = 1'b0;
    i_cap_len = '0; i_adc_strobe = 1'b0; i_cic_out_strobe = 1'b0;
    @(negedge clk);

    // Reset values
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk("rst_dec", 32'(o_cic_decimation), 32'd1);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_ready", 32'(o_cfg_ready), 32'd0);

    // cap_start ignored in IDLE
    nwr = 0;
    repeat (4) cyc(0, 0, 0, 1, 3);
    chk("idle_nwr", 32'(nwr), 32'd0);

    // Config handshake, zoom 3, flush with no writes
    cyc(0, 1, 3, 0, 0);
    chk("z3_dec", 32'(o_cic_decimation), 32'd8);
    chk("z3_rst_t1", 32'(o_cic_reset), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("z3_rst_t2", 32'(o_cic_reset), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("z3_rst_t3", 32'(o_cic_reset), 32'd0);
    settle("z3_settle");
    chk("z3_nwr", 32'(nwr), 32'd0);

    // Capture of 4 from ARMED
    nwr = 0;
    cyc(0, 0, 0, 1, 4);
    settle("cap4_settle");
    chk("cap4_nwr", 32'(nwr), 32'd4);

    // Pending start during FLUSH
    cyc(0, 1, 5, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    nwr = 0;
    cyc(0, 0, 0, 1, 2);
    settle("pend_settle");
    chk("pend_nwr", 32'(nwr), 32'd2);

    // Clamp and bypass
    cyc(0, 1, 15, 0, 0);
    chk("clamp_dec", 32'(o_cic_decimation), 32'd8192);
    chk("clamp_zoom", 32'(o_cur_zoom), 32'd13);
    settle("clamp_settle");
    cyc(0, 1, 0, 0, 0);
    chk("z0_dec", 32'(o_cic_decimation), 32'd1);
    settle("z0_settle");

    // Config held during capture is blocked until after cap_done
    cyc(0, 0, 0, 1, 8);
    for (int k = 0; k < 400; k++) begin
      if (o_busy !== 1'b1) break;
      cyc(0, 1, 2, 0, 0);
    end
    chk("blk_busy", 32'(o_busy), 32'd0);
    chk("blk_dec", 32'(o_cic_decimation), 32'd1);
    chk("blk_ready", 32'(o_cfg_ready), 32'd1);
    cyc(0, 1, 2, 0, 0);
    chk("blk_dec_after", 32'(o_cic_decimation), 32'd4);
    settle("blk_settle");

    // Zero-length capture
    nwr = 0;
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("len0_done", 32'(o_cap_done), 32'd1);
    chk("len0_nwr", 32'(nwr), 32'd0);

    // Reset in the middle of a capture
    cyc(0, 0, 0, 1, 20);
    repeat (10) cyc(0, 0, 0, 0, 0);
    chk("mid_busy", 32'(o_busy), 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_dec", 32'(o_cic_decimation), 32'd1);
    chk("mid_rst_zoom", 32'(o_cur_zoom), 32'd0);
    chk("mid_rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("mid_rst_done", 32'(o_cap_done), 32'd0);
    repeat (6) cyc(0, 0, 0, 0, 0);

    // Random traffic
    repeat (800) begin
      cyc(($urandom % 300) == 0, ($urandom % 40) == 0, int'($urandom % 16),
          ($urandom % 12) == 0, int'($urandom % 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wf_cic_ctrl.md
# wf_cic_ctrl

Sequencer for the waterfall's variable-decimation CIC decimator (5 stages, power-of-two decimation 1..8192). It converts a zoom command into a CIC decimation value, resets the CIC, gates its input strobe, and discards the settling outputs. It then writes a requested number of CIC output samples into the waterfall capture buffer. It sits between the register interface (zoom and capture commands) and the CIC/capture-buffer datapath.

## Interface

**Parameters**
- `MD`, 18: width of `cic_decimation`; must match the CIC's decimation port.
- `ZOOM_MAX`, 13: largest zoom; decimation = 2**zoom.
- `RST_CYC`, 2: cycles `cic_reset` is held after a config is accepted.
- `FLUSH`, 6: CIC output strobes discarded after reset (STAGES + 1).
- `CNT_W`, 11: capture length / buffer address width.

**Ports**
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `cfg_valid` in 1: zoom command valid.
- `cfg_zoom` in 4: requested zoom.
- `cfg_ready` out 1: command accepted when `cfg_valid && cfg_ready`.
- `cap_start` in 1: single-cycle capture request.
- `cap_len` in CNT_W: samples to capture; sampled with `cap_start`.
- `adc_strobe` in 1: input-rate sample strobe.
- `cic_reset` out 1: to the CIC `reset`.
- `cic_decimation` out MD: to the CIC `decimation`.
- `cic_in_strobe` out 1: to the CIC `in_strobe`.
- `cic_out_strobe` in 1: from the CIC `out_strobe`.
- `wr_strobe` out 1: capture-buffer write enable, aligned with the CIC `out_data`.
- `wr_addr` out CNT_W: capture-buffer write address.
- `cap_done` out 1: one-cycle pulse at end of capture.
- `busy` out 1: high in RESET, FLUSH and CAPTURE.
- `cur_zoom` out 4: currently applied zoom.

## Operation

**States:** IDLE, RESET, FLUSH, ARMED, CAPTURE.

- **IDLE:** entered after `reset`. `cic_in_strobe` is 0. `cfg_ready` is 1. `cap_start` is ignored.
- **Config accept** (only in IDLE or ARMED): `cur_zoom` is set to `min(cfg_zoom, ZOOM_MAX)`, `cic_decimation` to `1 << cur_zoom` (zero-extended to MD), and the state goes to RESET.
- **RESET:** `cic_reset` = 1 for exactly RST_CYC cycles, then the state goes to FLUSH. `cic_in_strobe` is 0 throughout.
- **FLUSH:** `cic_in_strobe` = `adc_strobe` delayed 1 cycle. The block counts `cic_out_strobe`; after the FLUSH-th strobe it goes to ARMED. No writes occur. A `cap_start` in FLUSH is latched (with `cap_len`) as pending; a later one overwrites it. On leaving FLUSH a pending start goes directly to CAPTURE.
- **ARMED:** the CIC keeps running and outputs are discarded. `cap_start` goes to CAPTURE. If `cfg_valid` and `cap_start` arrive in the same cycle, the config wins and `cap_start` is dropped.
- **CAPTURE:** `wr_addr` is cleared to 0 on entry. Each `cic_out_strobe` produces `wr_strobe` on the following cycle, matching the CIC's registered `out_data`. `wr_addr` increments after each write. After write number `cap_len` (address `cap_len-1`), `cap_done` pulses on the next cycle and the state returns to ARMED. `cfg_ready` is 0. `cap_start` is ignored.
- **`cap_len` = 0:** no writes; `cap_done` pulses the cycle after CAPTURE is entered.
- **Zoom 0** (decimation 1): valid; `cic_out_strobe` follows every input strobe.

## Timing

- **Reset values:** `cic_reset` 0, `cic_decimation` 1, `cic_in_strobe` 0, `wr_strobe` 0, `wr_addr` 0, `cap_done` 0, `busy` 0, `cur_zoom` 0, `cfg_ready` 0 while `reset` is high. A mid-operation reset aborts any flush or capture with no `cap_done`.
- **`cfg_ready`:** decoded from the state register (IDLE/ARMED), forced 0 during `reset`.
- **Config handshake:** accepted at cycle T. At T+1: `cic_decimation`/`cur_zoom` updated, `cic_reset` = 1, `busy` = 1. `cic_reset` is high for T+1..T+RST_CYC. FLUSH starts at T+RST_CYC+1.
- **Strobe latency:** `cic_in_strobe` lags `adc_strobe` by 1 cycle. `wr_strobe` lags `cic_out_strobe` by 1 cycle.
- **`cap_done`:** the cycle after the last `wr_strobe`. `busy` falls in the same cycle.
- **Counters:** the flush counter is sized to `$clog2(FLUSH+1)`. The write counter is CNT_W bits and never wraps, since capture ends at `cap_len`.

## Test plan

1. **Config handshake:** reset, then `cfg_zoom`=3 accepted at T → `cic_decimation`=8 at T+1; `cic_reset` high exactly T+1..T+2; `cic_in_strobe` 0 until FLUSH; no `wr_strobe` during the first 6 `cic_out_strobe`.
2. **Capture:** `cap_start` with `cap_len`=4 in ARMED → 4 `wr_strobe` with `wr_addr` 0,1,2,3, each 1 cycle after a `cic_out_strobe`; `cap_done` 1 cycle after the 4th; state returns to ARMED.
3. **Pending start in FLUSH:** `cap_start`(`cap_len`=2) during FLUSH → first write is on the output following the 6th discarded strobe; exactly 2 writes.
4. **Clamp and bypass:** `cfg_zoom`=15 → `cic_decimation`=8192, `cur_zoom`=13. `cfg_zoom`=0 → `cic_decimation`=1.
5. **Config blocked during capture:** `cfg_valid` held during CAPTURE → `cfg_ready` 0 and no decimation change until the cycle after `cap_done`, then accepted.
6. **Edge cases:** `reset` asserted mid-CAPTURE → next cycle all outputs at reset values, no `cap_done`. `cap_len`=0 → `cap_done` with zero writes.
